uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one byte-serial UART transmitter among NUM_REQ requesters using round-robin arbitration.
- Latches the winning requester's byte.
- Issues a one-cycle send strobe to the transmitter.
- Waits for the transmitter's done indication, then returns a per-requester completion pulse.
- Enforces a minimum inter-frame gap and a stuck-transmitter timeout.

It sits between the system's message sources (status, debug, command-response) and the single serial TX pin driver.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 2, idle clocks inserted after each completed frame (0 allowed)
TIMEOUT_MAX, 4095, clocks allowed in WAIT_DONE before abort; 12-bit counter

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_req  in  NUM_REQ  level request per requester
i_data  in  NUM_REQ*8  byte per requester; requester k at bits [8k+7:8k]
o_ack  out  NUM_REQ  one-hot one-cycle pulse: byte accepted from requester k
o_done  out  NUM_REQ  one-hot one-cycle pulse: requester k's frame finished
o_busy  out  1  high in any state other than IDLE
o_err  out  1  one-cycle pulse on timeout abort
o_send_en  out  1  one-cycle strobe to transmitter
o_tx_data  out  8  byte to transmitter; stable from LAUNCH until next LAUNCH
i_tx_done  in  1  transmitter done level; goes high at stop bit, low when transmitter idles

Interface: reset i_rst_n, asynchronous, active-low; clock i_clk. All outputs are registered.

Behaviour:
- Reset values: every output 0; state IDLE; RR pointer 0; owner 0; timeout and gap counters 0; i_tx_done edge register 0.
- IDLE, any i_req set:
  - Pick the first set request searching from (last_owner+1) mod NUM_REQ upward with wrap. After reset the search starts at index 0.
  - Register owner and o_tx_data = i_data[owner].
  - Pulse o_ack[owner] for one cycle, in the same cycle the state moves to LAUNCH.
- LAUNCH: o_send_en=1 for exactly one cycle (o_tx_data already valid). Clear timeout counter. Go to WAIT_DONE.
- WAIT_DONE:
  - Rising edge of i_tx_done (current high, registered previous low): pulse o_done[owner], set last_owner=owner, go to GAP. If GAP_CYCLES=0, go straight to IDLE.
  - Level-high i_tx_done left over from an earlier frame is ignored; only a 0->1 edge counts.
  - Timeout counter increments each cycle. When it reaches TIMEOUT_MAX: pulse o_err, no o_done, last_owner=owner, go to GAP.
- GAP: count GAP_CYCLES clocks, then go to IDLE. Requests arriving in GAP are held pending, not lost.
- Latency:
  - req seen in IDLE -> o_ack on the next edge.
  - o_send_en 1 cycle after o_ack.
  - o_done 1 cycle after the i_tx_done rising edge.
- Requester rules:
  - Hold i_req and i_data stable until o_ack. i_data is sampled only in the ack cycle.
  - Dropping i_req before o_ack withdraws the request with no side effect.
  - Requester may reassert i_req immediately after o_ack. It is queued, but RR fairness serves other pending requesters first.
- Simultaneous events:
  - o_done and a new request in the same cycle: the request waits for IDLE.
  - All requesters asserted: strict rotation 0,1,2,3,0...
- Reset mid-frame: immediate return to IDLE, outputs 0, no o_done or o_err. The transmitter's in-flight frame is its own concern.
- Widths: pointer is $clog2(NUM_REQ) bits with explicit wrap at NUM_REQ-1 (non-power-of-2 NUM_REQ must wrap correctly). Gap counter is sized for GAP_CYCLES.

Optional Feature:
UART_ARB_PRIO0_EN
- Defined: requester 0 is urgent. If i_req[0] is set in IDLE it wins regardless of the RR pointer. last_owner is not updated when requester 0 wins, so rotation among requesters 1..NUM_REQ-1 is preserved.
- Undefined: pure round-robin across all requesters, as above.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum {IDLE, LAUNCH, WAIT_DONE, GAP}
  - byte width constant (8)
  - timeout counter width (12)
  - bit-slice helper for i_data.
- One sub-module, uart_rr_picker: combinational, takes the request vector and last_owner, returns a valid flag and winner index. It is instantiated once in the arbiter.

Test Plan:
- Single request: i_req=0001, data 0xA5 -> o_ack=0001 next cycle; o_send_en 1 cycle later with o_tx_data=0xA5; model raises i_tx_done -> o_done=0001; o_busy low after GAP_CYCLES=2.
- All four requesting continuously, data 0x10..0x13 -> grant order 0,1,2,3,0 with matching o_tx_data; each o_send_en spaced at least frame+2+2 cycles apart.
- Transmitter model never raises i_tx_done -> o_err pulse exactly TIMEOUT_MAX cycles after o_send_en; no o_done; next requester served afterward.
- i_tx_done held high from the previous frame across the next LAUNCH -> no premature o_done; o_done only after the low->high edge.
- i_rst_n asserted in WAIT_DONE -> all outputs 0 asynchronously; after release, i_req=0100 -> o_ack=0100 (pointer restarts at 0).
- With UART_ARB_PRIO0_EN and i_req=1111 constant -> requester 0 wins every arbitration; without the macro -> rotation 0,1,2,3.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Optional feature macro used by the arbiter: UART_ARB_PRIO0_EN (requester 0 always wins).
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arb_state_t;

    localparam int BYTE_W  = 8;
    localparam int TMO_W   = 12;
    localparam int MAX_REQ = 8;

    // Byte k of a packed requester data bus (bus padded to MAX_REQ bytes).
    function automatic logic [BYTE_W-1:0] byte_sel(
        input logic [MAX_REQ*BYTE_W-1:0] data,
        input logic [2:0]                idx
    );
        return data[idx*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request at or after 'start', with wrap.
module uart_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   start,
    output logic               valid,
    output logic [PTR_W-1:0]   winner
);

    int idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(start) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!valid && req[idx[PTR_W-1:0]]) begin
                valid  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-serial UART transmitter among NUM_REQ requesters.
// Optional: define UART_ARB_PRIO0_EN to make requester 0 win every arbitration it joins.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT_MAX = 4095
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_REQ-1:0]      i_req,
    input  logic [NUM_REQ*8-1:0]    i_data,
    output logic [NUM_REQ-1:0]      o_ack,
    output logic [NUM_REQ-1:0]      o_done,
    output logic                    o_busy,
    output logic                    o_err,
    output logic                    o_send_en,
    output logic [BYTE_W-1:0]       o_tx_data,
    input  logic                    i_tx_done
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_MAX - 1);
    localparam arb_state_t AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

    arb_state_t               state, state_nx;
    logic [PTR_W-1:0]         owner, owner_nx, rr_ptr, ptr_nx, win;
    logic [TMO_W-1:0]         tmo_cnt, tmo_nx;
    logic [GAP_W-1:0]         gap_cnt, gap_nx;
    logic                     tx_done_q, done_rise, prio_win;
    logic                     pick_valid;
    logic [PTR_W-1:0]         pick_idx;
    logic [BYTE_W-1:0]        data_nx;
    logic [NUM_REQ-1:0]       ack_nx, done_nx;
    logic                     err_nx, send_nx;
    logic [MAX_REQ*BYTE_W-1:0] data_pad;

    assign data_pad  = (MAX_REQ*BYTE_W)'(i_data);
    assign done_rise = i_tx_done & ~tx_done_q;

`ifdef UART_ARB_PRIO0_EN
    assign prio_win = i_req[0];
`else
    assign prio_win = 1'b0;
`endif

    uart_rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
        .req    (i_req),
        .start  (rr_ptr),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // rr_ptr holds the next search start; updating it at grant is equivalent to
    // updating at frame end because no arbitration happens in between.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        ptr_nx   = rr_ptr;
        tmo_nx   = tmo_cnt;
        gap_nx   = gap_cnt;
        data_nx  = o_tx_data;
        ack_nx   = '0;
        done_nx  = '0;
        err_nx   = 1'b0;
        send_nx  = 1'b0;
        win      = prio_win ? '0 : pick_idx;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    owner_nx    = win;
                    data_nx     = byte_sel(data_pad, 3'(win));
                    ack_nx[win] = 1'b1;
                    if (!prio_win) ptr_nx = wrap_inc(win);
                    state_nx    = LAUNCH;
                end
            end
            LAUNCH: begin
                send_nx  = 1'b1;
                tmo_nx   = '0;
                state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_rise) begin
                    done_nx[owner] = 1'b1;
                    gap_nx         = '0;
                    state_nx       = AFTER_FRAME;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_nx   = 1'b1;
                    gap_nx   = '0;
                    state_nx = AFTER_FRAME;
                end else begin
                    tmo_nx = tmo_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nx = IDLE;
                else                     gap_nx   = gap_cnt + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
            tx_done_q <= 1'b0;
            o_ack     <= '0;
            o_done    <= '0;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
            o_send_en <= 1'b0;
            o_tx_data <= '0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            rr_ptr    <= ptr_nx;
            tmo_cnt   <= tmo_nx;
            gap_cnt   <= gap_nx;
            tx_done_q <= i_tx_done;
            o_ack     <= ack_nx;
            o_done    <= done_nx;
            o_busy    <= (state_nx != IDLE);
            o_err     <= err_nx;
            o_send_en <= send_nx;
            o_tx_data <= data_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, GAP_CYCLES=2, TIMEOUT_MAX=4095).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data;
    logic        tx_done;
    logic [3:0]  ack, done;
    logic        busy, err, send_en;
    logic [7:0]  tx_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_send = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(2), .TIMEOUT_MAX(4095)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_data    (data),
        .o_ack     (ack),
        .o_done    (done),
        .o_busy    (busy),
        .o_err     (err),
        .o_send_en (send_en),
        .o_tx_data (tx_data),
        .i_tx_done (tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack();
        int n = 0;
        while (ack == 4'b0 && n < 20) begin
            tick();
            n++;
        end
    endtask

    // One full frame: ack, send strobe with byte, transmitter done after 4 cycles.
    task automatic serve(input int idx, input logic [7:0] byte_exp, input bit drop);
        wait_ack();
        check("ack", 32'(ack), 32'(1) << idx);
        if (drop) req[idx] = 1'b0;
        tick();
        check("send_en", 32'(send_en), 32'd1);
        check("tx_data", 32'(tx_data), 32'(byte_exp));
        last_send = cyc;
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        check("done", 32'(done), 32'(1) << idx);
        tx_done = 1'b0;
    endtask

    initial begin
        int prev_send, n, exp_idx;
        bit saw_done;

        rst_n = 1'b0; req = '0; data = '0; tx_done = 1'b0;
        repeat (2) tick();
        check("rst_outs", {ack, done, busy, err, send_en, tx_data}, 32'd0);
        rst_n = 1'b1;

        // single request
        req = 4'b0001; data = 32'h0000_00A5;
        serve(0, 8'hA5, 1'b1);
        tick();
        check("gap_busy", 32'(busy), 32'd1);
        check("done_pulse", 32'(done), 32'd0);
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // all requesting continuously, fresh pointer
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req = 4'b1111; data = 32'h1312_1110;
        prev_send = 0;
        for (int i = 0; i < 5; i++) begin
`ifdef UART_ARB_PRIO0_EN
            exp_idx = 0;
`else
            exp_idx = i % 4;
`endif
            serve(exp_idx, 8'h10 + 8'(exp_idx), 1'b0);
            if (i > 0) check("send_spacing", 32'(last_send - prev_send), 32'd8);
            prev_send = last_send;
        end
        req = '0;

        // transmitter never completes
        req = 4'b0010; data = 32'h7766_5A44;
        wait_ack();
        check("tmo_ack", 32'(ack), 32'b0010);
        req = 4'b1100;
        tick();
        check("tmo_send", 32'(send_en), 32'd1);
        check("tmo_data", 32'(tx_data), 32'h5A);
        last_send = cyc;
        n = 0; saw_done = 1'b0;
        while (err == 1'b0 && n < 5000) begin
            tick();
            n++;
            if (done != 4'b0) saw_done = 1'b1;
        end
        check("err_time", 32'(cyc - last_send), 32'd4095);
        check("no_done", 32'(saw_done), 32'd0);
        tick();
        check("err_pulse", 32'(err), 32'd0);
        serve(2, 8'h66, 1'b1);

        // done level left high across the next launch
        tx_done = 1'b1;
        wait_ack();
        check("lvl_ack", 32'(ack), 32'b1000);
        req = '0;
        tick();
        check("lvl_data", 32'(tx_data), 32'h77);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lvl_no_done", 32'(done), 32'd0);
        end
        tx_done = 1'b0;
        tick();
        check("lvl_low", 32'(done), 32'd0);
        tx_done = 1'b1;
        tick();
        check("lvl_edge", 32'(done), 32'b1000);
        tx_done = 1'b0;

        // reset while waiting for done; pointer must restart at 0
        req = 4'b0100;
        wait_ack();
        check("mid_ack", 32'(ack), 32'b0100);
        req = '0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_data", 32'(tx_data), 32'd0);
        check("async_outs", {ack, done, err, send_en}, 32'd0);
        tick();
        rst_n = 1'b1;
        req = 4'b1010;
        serve(1, 8'h5A, 1'b1);
        serve(3, 8'h77, 1'b1);
        repeat (5) tick();
        check("final_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
